lfsr_event_detector: RTL and testbench
======================================

Name: lfsr_event_detector

Overview:
- Downstream consumer of the 20-bit LFSR counter stream.
- Each cycle, compares the incoming LFSR state against a programmable masked pattern.
- Counts matches while armed and, once a threshold count is reached, asserts a fixed-length `fire` pulse.
- Provides the event/trigger stage that turns raw LFSR sequence output into a timed control strobe for the surrounding datapath.

Parameters:
- WIDTH, 20: width of the LFSR input, pattern and mask.
- COUNT_W, 8: width of the match counter.
- THRESH, 4: match count that triggers FIRE. Legal range is 1..2^COUNT_W-1.
- HOLD_CYCLES, 16: number of cycles `fire` stays high. Must be >= 1.
- DEFAULT_PATTERN, 20'h00001: pattern register value at reset.
- WINDOW, 64: inactivity window in cycles; used only with MATCH_WINDOW_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- lfsr_in  in  WIDTH  LFSR state, sampled every cycle.
- cfg_load  in  1  load pattern/mask registers; honoured only in IDLE.
- pattern_in  in  WIDTH  pattern value captured on cfg_load.
- mask_in  in  WIDTH  compare mask captured on cfg_load; 1 = bit compared.
- arm  in  1  IDLE -> ARMED request.
- disarm  in  1  ARMED -> IDLE request.
- clear  in  1  synchronous abort: return to IDLE, zero counters.
- hit  out  1  registered match flag.
- match_count  out  COUNT_W  current match count.
- fire  out  1  high for HOLD_CYCLES cycles after threshold is reached.
- state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 FIRE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, hit=0, match_count=0, fire=0, hold counter=0.
  - pattern_q=DEFAULT_PATTERN, mask_q=all ones.
- Match path:
  - hit is registered from `((lfsr_in ^ pattern_q) & mask_q) == 0`.
  - Latency is 1 cycle: lfsr_in at edge N is reflected in hit after edge N.
  - hit is computed in every state.
  - mask_q=0 means hit=1 every cycle.
- cfg_load:
  - In IDLE, captures pattern_in and mask_in at the edge; the new values affect hit from the following edge.
  - Ignored in ARMED and FIRE.
- Priority per edge: clear > disarm > arm > normal operation.
- IDLE:
  - arm=1 -> ARMED. match_count is already 0.
  - hit is ignored for counting.
- ARMED:
  - On an edge where hit=1, match_count increments.
  - If the incremented value equals THRESH, on the same edge: state -> FIRE, hold counter loads HOLD_CYCLES-1.
  - disarm=1 -> IDLE, match_count=0; any concurrent hit is not counted.
  - arm is ignored.
- FIRE:
  - fire = (state==FIRE), decoded directly from the state register, no extra delay.
  - The hold counter decrements each edge. On an edge where it is 0: state -> IDLE, match_count=0.
  - fire is therefore high for exactly HOLD_CYCLES cycles.
  - arm, disarm and hits are ignored; match_count holds at THRESH.
- clear=1 in any state: on that edge, state=IDLE, match_count=0, hold counter=0. clear does not alter pattern_q, mask_q or hit.
- Saturation: match_count never wraps. Because THRESH fires first, the saturation guard only matters if THRESH is misparameterised; saturate at all ones in that case.
- state encoding 3 is unreachable; if entered, the next edge goes to IDLE.

Optional Feature:
- Macro MATCH_WINDOW_EN.
- When defined:
  - In ARMED, an inactivity counter (width clog2(WINDOW+1)) counts consecutive edges with hit=0 and resets to 0 on any hit.
  - When it reaches WINDOW, match_count returns to 0 on that edge; state stays ARMED and the inactivity counter restarts.
  - The inactivity counter is 0 outside ARMED.
- When undefined: no inactivity logic; match_count accumulates indefinitely while ARMED.

Test Plan:
- Reset: with rst=0 mid-FIRE -> fire=0, state=0, match_count=0 immediately (asynchronous), pattern_q returns to 20'h00001.
- Exact match: cfg_load pattern=20'hA5A5A, mask=20'hFFFFF; arm; drive lfsr_in=20'hA5A5A for 4 cycles -> hit rises 1 cycle after the first sample, match_count steps 1..4, fire high for exactly 16 cycles, then state=IDLE and match_count=0.
- Masked compare: mask=20'h0000F, pattern=20'h00003; lfsr_in=20'hFFF03 -> hit=1; lfsr_in=20'hFFF04 -> hit=0.
- Precedence: in ARMED with match_count=3 and hit=1, assert arm+disarm together -> state=IDLE, match_count=0, no fire. Then cfg_load in ARMED -> pattern_q unchanged.
- clear during FIRE at hold count 10 -> next cycle fire=0, state=IDLE; a new arm plus 4 hits fires again for the full 16 cycles.
- MATCH_WINDOW_EN, WINDOW=8: 2 hits, then 8 non-hit cycles -> match_count drops to 0 and state stays ARMED. The same stimulus without the macro keeps match_count=2.

Source files
------------

// File: rtl/lfsr_event_detector.sv
// ---------------------------------------------------------------------------
// lfsr_event_detector
//
// Watches a free-running LFSR state stream and compares every sample against
// a programmable masked pattern. While armed, matches are counted; when the
// count reaches THRESH a fixed-length fire strobe is produced.
//
// Optional build macro: MATCH_WINDOW_EN
//   When defined, WINDOW consecutive non-matching cycles while armed discard
//   the accumulated match count (the detector stays armed).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   lfsr_in      LFSR state, sampled every cycle
//   cfg_load     load pattern/mask (honoured only in IDLE)
//   pattern_in   pattern captured on cfg_load
//   mask_in      compare mask captured on cfg_load (1 = bit compared)
//   arm          IDLE -> ARMED request
//   disarm       ARMED -> IDLE request
//   clear        synchronous abort to IDLE, counters zeroed
//   hit          registered match flag
//   match_count  current match count
//   fire         high for HOLD_CYCLES cycles once the threshold is reached
//   state        FSM state: 0 IDLE, 1 ARMED, 2 FIRE
// ---------------------------------------------------------------------------
module lfsr_event_detector #(
    parameter int unsigned       WIDTH           = 20,
    parameter int unsigned       COUNT_W         = 8,
    parameter int unsigned       THRESH          = 4,
    parameter int unsigned       HOLD_CYCLES     = 16,
    parameter logic [WIDTH-1:0]  DEFAULT_PATTERN = 20'h00001,
    parameter int unsigned       WINDOW          = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   lfsr_in,
    input  logic               cfg_load,
    input  logic [WIDTH-1:0]   pattern_in,
    input  logic [WIDTH-1:0]   mask_in,
    input  logic               arm,
    input  logic               disarm,
    input  logic               clear,
    output logic               hit,
    output logic [COUNT_W-1:0] match_count,
    output logic               fire,
    output logic [1:0]         state
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] THRESH_C  = COUNT_W'(THRESH);
    // A THRESH beyond the counter range can never be reached; the counter
    // then simply saturates instead of firing on a truncated value.
    localparam bit                 THRESH_OK = ((THRESH >> COUNT_W) == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    // Reject parameter values the datapath cannot represent.
    if ((THRESH < 1) || (HOLD_CYCLES < 1) || (WINDOW < 1)) begin : g_bad_params
        $error("lfsr_event_detector: THRESH, HOLD_CYCLES and WINDOW must be >= 1");
    end

    // Masked equality: only bits with mask=1 take part in the compare.
    function automatic logic masked_match(input logic [WIDTH-1:0] value,
                                          input logic [WIDTH-1:0] pattern,
                                          input logic [WIDTH-1:0] mask);
        return (((value ^ pattern) & mask) == {WIDTH{1'b0}});
    endfunction

    logic [WIDTH-1:0]   pattern_r;
    logic [WIDTH-1:0]   mask_r;
    logic               hit_r;
    state_t             state_r;
    state_t             state_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_s;
    logic [COUNT_W-1:0] count_inc_s;
    logic [HOLD_W-1:0]  hold_r;
    logic [HOLD_W-1:0]  hold_s;
    logic               fire_r;
`ifdef MATCH_WINDOW_EN
    localparam int unsigned INACT_W = $clog2(WINDOW + 1);
    logic [INACT_W-1:0] inact_r;
    logic [INACT_W-1:0] inact_s;
    logic [INACT_W-1:0] inact_inc_s;
`endif

    // Pattern/mask configuration, writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_r <= DEFAULT_PATTERN;
            mask_r    <= {WIDTH{1'b1}};
        end else if (cfg_load && (state_r == ST_IDLE)) begin
            pattern_r <= pattern_in;
            mask_r    <= mask_in;
        end
    end

    // Registered compare, evaluated in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_r <= 1'b0;
        end else begin
            hit_r <= masked_match(lfsr_in, pattern_r, mask_r);
        end
    end

    // Next-state, match counter and hold counter decode.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        hold_s      = hold_r;
        count_inc_s = (count_r == {COUNT_W{1'b1}}) ? count_r : (count_r + COUNT_W'(1));
`ifdef MATCH_WINDOW_EN
        inact_s     = {INACT_W{1'b0}};
        inact_inc_s = inact_r + INACT_W'(1);
`endif
        if (clear) begin
            state_s = ST_IDLE;
            count_s = {COUNT_W{1'b0}};
            hold_s  = {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_s = {COUNT_W{1'b0}};
                    // disarm outranks arm even when idle
                    if (disarm) begin
                        state_s = ST_IDLE;
                    end else if (arm) begin
                        state_s = ST_ARMED;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (disarm) begin
                        state_s = ST_IDLE;
                        count_s = {COUNT_W{1'b0}};
                    end else if (hit_r) begin
                        count_s = count_inc_s;
                        if (THRESH_OK && (count_inc_s == THRESH_C)) begin
                            state_s = ST_FIRE;
                            hold_s  = HOLD_LOAD;
                        end else begin
                            state_s = ST_ARMED;
                        end
                    end else begin
`ifdef MATCH_WINDOW_EN
                        if (inact_inc_s == INACT_W'(WINDOW)) begin
                            count_s = {COUNT_W{1'b0}};
                            inact_s = {INACT_W{1'b0}};
                        end else begin
                            inact_s = inact_inc_s;
                        end
`else
                        count_s = count_r;
`endif
                    end
                end
                ST_FIRE: begin
                    if (hold_r == {HOLD_W{1'b0}}) begin
                        state_s = ST_IDLE;
                        count_s = {COUNT_W{1'b0}};
                    end else begin
                        hold_s = hold_r - HOLD_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = {COUNT_W{1'b0}};
                    hold_s  = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // FSM, counter and fire registers; fire tracks the FIRE state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            count_r <= {COUNT_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            fire_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            hold_r  <= hold_s;
            fire_r  <= (state_s == ST_FIRE);
        end
    end

`ifdef MATCH_WINDOW_EN
    // Inactivity counter, held at zero outside ARMED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inact_r <= {INACT_W{1'b0}};
        end else begin
            inact_r <= inact_s;
        end
    end
`endif

    assign hit         = hit_r;
    assign match_count = count_r;
    assign fire        = fire_r;
    assign state       = state_r;

endmodule

// File: tb/tb_lfsr_event_detector.sv
// ---------------------------------------------------------------------------
// tb_lfsr_event_detector
//
// Directed stimulus with hand-computed expectations. Each stimulus cycle
// pushes the expected post-edge outputs into a queue; an independent monitor
// pops and compares after every rising edge (or on demand for the
// asynchronous reset check).
// ---------------------------------------------------------------------------
module tb_lfsr_event_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] lfsr_in    = 20'h0;
    logic        cfg_load   = 1'b0;
    logic [19:0] pattern_in = 20'h0;
    logic [19:0] mask_in    = 20'h0;
    logic        arm        = 1'b0;
    logic        disarm     = 1'b0;
    logic        clear      = 1'b0;
    logic        hit;
    logic [7:0]  match_count;
    logic        fire;
    logic [1:0]  state;

    typedef struct {
        int id;
        int h;
        int c;
        int s;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   next_id = 0;
    event chk_ev;

    lfsr_event_detector #(
        .WIDTH(20), .COUNT_W(8), .THRESH(4), .HOLD_CYCLES(16),
        .DEFAULT_PATTERN(20'h00001), .WINDOW(8)
    ) dut (
        .clk(clk), .rst(rst), .lfsr_in(lfsr_in), .cfg_load(cfg_load),
        .pattern_in(pattern_in), .mask_in(mask_in), .arm(arm),
        .disarm(disarm), .clear(clear), .hit(hit),
        .match_count(match_count), .fire(fire), .state(state)
    );

    always #5 clk = ~clk;

    task automatic push(input int h, input int c, input int s);
        exp_t e;
        e.id = next_id;
        e.h  = h;
        e.c  = c;
        e.s  = s;
        next_id++;
        exp_q.push_back(e);
    endtask

    // Inputs are set at a falling edge; the expectation applies after the
    // following rising edge. Single-cycle controls are dropped afterwards.
    task automatic tick(input int h, input int c, input int s);
        push(h, c, s);
        @(negedge clk);
        cfg_load = 1'b0;
        arm      = 1'b0;
        disarm   = 1'b0;
        clear    = 1'b0;
    endtask

    // Arm, feed four matching samples, then either watch the full fire
    // window (n_before_clear == 0) or clear after n_before_clear fire cycles.
    task automatic fire_seq(input int n_before_clear);
        arm = 1'b1; lfsr_in = 20'h00000;
        tick(0, 0, 1);
        lfsr_in = 20'hA5A5A;
        for (int i = 0; i < 4; i++) tick(1, i, 1);
        if (n_before_clear == 0) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 3) begin arm = 1'b1; disarm = 1'b1; end
                tick(1, 4, 2);
            end
            lfsr_in = 20'h00000;
            tick(0, 0, 0);
        end else begin
            lfsr_in = 20'h00000;
            for (int i = 0; i < n_before_clear; i++) tick(0, 4, 2);
            clear = 1'b1;
            tick(0, 0, 0);
            tick(0, 0, 0);
        end
    endtask

    // Monitor: compares the oldest expectation against the DUT outputs.
    initial begin : monitor
        exp_t e;
        logic exp_fire;
        forever begin
            @(posedge clk or chk_ev);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_fire = (e.s == 2);
                checks++;
                if ((hit !== e.h[0]) || (match_count !== e.c[7:0]) ||
                    (state !== e.s[1:0]) || (fire !== exp_fire)) begin
                    errors++;
                    $display("FAIL chk%0d: got hit=%0b count=%0d state=%0d fire=%0b, want hit=%0b count=%0d state=%0d fire=%0b",
                             e.id, hit, match_count, state, fire,
                             e.h[0], e.c, e.s, exp_fire);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state, checked while reset is held
        #1 rst = 1'b0;
        #2 push(0, 0, 0);
        -> chk_ev;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Default pattern 0x00001 with full mask
        lfsr_in = 20'h00001; tick(1, 0, 0);
        lfsr_in = 20'h00003; tick(0, 0, 0);

        // Exact match: load A5A5A/FFFFF, fire for the full window
        cfg_load = 1'b1; pattern_in = 20'hA5A5A; mask_in = 20'hFFFFF;
        lfsr_in = 20'h00000;
        tick(0, 0, 0);
        fire_seq(0);

        // Masked compare, then mask=0 always hits
        cfg_load = 1'b1; pattern_in = 20'h00003; mask_in = 20'h0000F;
        lfsr_in = 20'h00000; tick(0, 0, 0);
        lfsr_in = 20'hFFF03; tick(1, 0, 0);
        lfsr_in = 20'hFFF04; tick(0, 0, 0);
        cfg_load = 1'b1; mask_in = 20'h00000; tick(0, 0, 0);
        lfsr_in = 20'h12345; tick(1, 0, 0);
        cfg_load = 1'b1; pattern_in = 20'hA5A5A; mask_in = 20'hFFFFF;
        lfsr_in = 20'h00000; tick(1, 0, 0);
        tick(0, 0, 0);

        // Precedence: arm+disarm with count=3 and hit=1 goes idle, no fire
        arm = 1'b1; tick(0, 0, 1);
        lfsr_in = 20'hA5A5A;
        for (int i = 0; i < 4; i++) tick(1, i, 1);
        arm = 1'b1; disarm = 1'b1; lfsr_in = 20'h00000;
        tick(0, 0, 0);
        tick(0, 0, 0);
        // cfg_load while armed is ignored
        arm = 1'b1; tick(0, 0, 1);
        cfg_load = 1'b1; pattern_in = 20'h00000; mask_in = 20'hFFFFF;
        tick(0, 0, 1);
        tick(0, 0, 1);
        lfsr_in = 20'hA5A5A; tick(1, 0, 1);
        // disarm with a pending hit: the hit is not counted
        disarm = 1'b1; lfsr_in = 20'h00000; tick(0, 0, 0);

        // clear during FIRE at hold count 10, then a full re-fire
        fire_seq(6);
        fire_seq(0);

        // Inactivity window (WINDOW=8)
        arm = 1'b1; tick(0, 0, 1);
        lfsr_in = 20'hA5A5A; tick(1, 0, 1); tick(1, 1, 1);
        lfsr_in = 20'h00000; tick(0, 2, 1);
        for (int i = 0; i < 7; i++) tick(0, 2, 1);
`ifdef MATCH_WINDOW_EN
        tick(0, 0, 1);
        tick(0, 0, 1);
`else
        tick(0, 2, 1);
        tick(0, 2, 1);
`endif
        disarm = 1'b1; tick(0, 0, 0);

        // Asynchronous reset in the middle of FIRE
        arm = 1'b1; tick(0, 0, 1);
        lfsr_in = 20'hA5A5A;
        for (int i = 0; i < 4; i++) tick(1, i, 1);
        lfsr_in = 20'h00000;
        for (int i = 0; i < 3; i++) tick(0, 4, 2);
        rst = 1'b0;
        #1 push(0, 0, 0);
        -> chk_ev;
        #3;
        @(negedge clk);
        rst = 1'b1;
        // Pattern register back to 0x00001
        lfsr_in = 20'h00001; tick(1, 0, 0);
        lfsr_in = 20'hA5A5A; tick(0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
